// File: rtl/mem_io_bus_arbiter_pkg.sv
// Shared constants and types for the data-side memory/IO arbiter.
// Holds the IO map, the access state encoding and the decoded address region.
package mem_io_bus_arbiter_pkg;

    localparam logic [31:0] PKG_IO_BASE  = 32'hFFFF_FC00;
    localparam logic [31:0] PKG_LED_ADDR = 32'hFFFF_FC60;
    localparam logic [31:0] PKG_SW_ADDR  = 32'hFFFF_FC70;

    localparam logic GRANT_CPU  = 1'b0;
    localparam logic GRANT_UART = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        MEM_WR,
        MEM_RD,
        RD_WAIT,
        IO_WR,
        IO_RD,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        RGN_MEM,
        RGN_LED,
        RGN_SW,
        RGN_UNMAPPED
    } region_e;

endpackage

// File: rtl/mem_io_bus_arbiter_addr_decode.sv
// Combinational address decoder: maps a byte address onto memory, LED,
// switch or unmapped IO space.
module mem_io_addr_decode
    import mem_io_bus_arbiter_pkg::*;
#(
    parameter int                 DATA_W   = 32,
    parameter logic [DATA_W-1:0]  IO_BASE  = DATA_W'(PKG_IO_BASE),
    parameter logic [DATA_W-1:0]  LED_ADDR = DATA_W'(PKG_LED_ADDR),
    parameter logic [DATA_W-1:0]  SW_ADDR  = DATA_W'(PKG_SW_ADDR)
) (
    input  logic [DATA_W-1:0] addr,
    output region_e           region
);

    always_comb begin
        if (addr < IO_BASE) begin
            region = RGN_MEM;
        end else if (addr == LED_ADDR) begin
            region = RGN_LED;
        end else if (addr == SW_ADDR) begin
            region = RGN_SW;
        end else begin
            region = RGN_UNMAPPED;
        end
    end

endmodule

// File: rtl/mem_io_bus_arbiter.sv
// Data-side access sequencer: round-robin arbitration between the CPU
// load/store path and the write-only UART loader, with memory/IO decode.
//
//   state   | meaning
//   IDLE    | sample requests, arbitrate, latch winner
//   MEM_WR  | one-cycle memory write, completion pulse
//   MEM_RD  | memory address presented
//   RD_WAIT | extra read-latency cycles (down-counter)
//   IO_WR   | LED write (or ignored IO write), completion pulse
//   IO_RD   | switch read (or unmapped read returning 0)
//   RESP    | load data visible, completion pulse
module mem_io_bus_arbiter
    import mem_io_bus_arbiter_pkg::*;
#(
    parameter int                 DATA_W     = 32,
    parameter logic [DATA_W-1:0]  IO_BASE    = DATA_W'(PKG_IO_BASE),
    parameter logic [DATA_W-1:0]  LED_ADDR   = DATA_W'(PKG_LED_ADDR),
    parameter logic [DATA_W-1:0]  SW_ADDR    = DATA_W'(PKG_SW_ADDR),
    parameter int                 MEM_RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_stall,
    input  logic              uart_req,
    input  logic [DATA_W-1:0] uart_addr,
    input  logic [DATA_W-1:0] uart_wdata,
    output logic              uart_ack,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              led_cs,
    output logic [15:0]       led_wdata,
    output logic              sw_cs,
    input  logic [15:0]       sw_rdata,
    output logic              grant_uart
);

    localparam logic [1:0] WAIT_INIT = (MEM_RD_LAT > 1) ? 2'(MEM_RD_LAT - 2) : 2'd0;

    state_e            state;
    state_e            next_state;
    logic              last_grant;
    logic              owner_uart;
    region_e           region_q;
    logic [15:0]       led_data_q;
    logic [1:0]        wait_cnt;

    logic              req_any;
    logic              req_both;
    logic              win_uart;
    logic              win_we;
    logic [DATA_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    region_e           win_region;
    logic              done_pulse;

    assign req_any   = cpu_req | uart_req;
    assign req_both  = cpu_req & uart_req;
    // On a tie the requester that did not win the previous tie goes next.
    assign win_uart  = req_both ? (last_grant == GRANT_CPU) : uart_req;
    assign win_addr  = win_uart ? uart_addr  : cpu_addr;
    assign win_wdata = win_uart ? uart_wdata : cpu_wdata;
    assign win_we    = win_uart | cpu_we;

    mem_io_addr_decode #(
        .DATA_W   (DATA_W),
        .IO_BASE  (IO_BASE),
        .LED_ADDR (LED_ADDR),
        .SW_ADDR  (SW_ADDR)
    ) u_decode (
        .addr   (win_addr),
        .region (win_region)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_any) begin
                    if (win_region == RGN_MEM) begin
                        next_state = win_we ? MEM_WR : MEM_RD;
                    end else begin
                        next_state = win_we ? IO_WR : IO_RD;
                    end
                end
            end
            MEM_RD:  next_state = (MEM_RD_LAT > 1) ? RD_WAIT : RESP;
            RD_WAIT: if (wait_cnt == 2'd0) next_state = RESP;
            IO_RD:   next_state = RESP;
            MEM_WR,
            IO_WR,
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= GRANT_UART;
            owner_uart <= 1'b0;
            region_q   <= RGN_MEM;
            led_data_q <= 16'h0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rdata  <= '0;
            wait_cnt   <= 2'd0;
        end else begin
            if (state == IDLE && req_any) begin
                owner_uart <= win_uart;
                region_q   <= win_region;
                led_data_q <= win_wdata[15:0];
                if (req_both) begin
                    last_grant <= win_uart;
                end
                // Memory bus only moves for memory targets; it holds otherwise.
                if (win_region == RGN_MEM) begin
                    mem_addr  <= win_addr;
                    mem_wdata <= win_wdata;
                end
            end
            if (state == MEM_RD) begin
                wait_cnt <= WAIT_INIT;
            end else if (state == RD_WAIT && wait_cnt != 2'd0) begin
                wait_cnt <= wait_cnt - 2'd1;
            end
            if (next_state == RESP) begin
                if (state == IO_RD) begin
                    cpu_rdata <= (region_q == RGN_SW) ? {{(DATA_W-16){1'b0}}, sw_rdata} : '0;
                end else begin
                    cpu_rdata <= mem_rdata;
                end
            end
        end
    end

    always_comb begin
        done_pulse = (state == MEM_WR) || (state == IO_WR) || (state == RESP);
        cpu_done   = done_pulse & ~owner_uart;
        uart_ack   = done_pulse &  owner_uart;
        grant_uart = owner_uart & (state != IDLE);
        mem_we     = (state == MEM_WR);
        led_cs     = (state == IO_WR) && (region_q == RGN_LED) && !owner_uart;
        sw_cs      = (state == IO_RD) && (region_q == RGN_SW);
        led_wdata  = led_cs ? led_data_q : 16'h0;
    end

    assign cpu_stall = cpu_req & ~cpu_done;

endmodule

// File: tb/tb_mem_io_bus_arbiter.sv
// Directed bench for mem_io_bus_arbiter: instance a uses MEM_RD_LAT = 1,
// instance b uses MEM_RD_LAT = 3; both share one stimulus.
module tb_mem_io_bus_arbiter;
    import mem_io_bus_arbiter_pkg::*;

    logic        clock;
    logic        reset;
    logic        cpu_req, cpu_we, uart_req;
    logic [31:0] cpu_addr, cpu_wdata, uart_addr, uart_wdata, mem_rdata;
    logic [15:0] sw_rdata;

    logic [31:0] cpu_rdata_a, mem_addr_a, mem_wdata_a;
    logic        cpu_done_a, cpu_stall_a, uart_ack_a, mem_we_a, led_cs_a, sw_cs_a, grant_uart_a;
    logic [15:0] led_wdata_a;
    logic [31:0] cpu_rdata_b, mem_addr_b, mem_wdata_b;
    logic        cpu_done_b, cpu_stall_b, uart_ack_b, mem_we_b, led_cs_b, sw_cs_b, grant_uart_b;
    logic [15:0] led_wdata_b;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    mem_io_bus_arbiter #(.MEM_RD_LAT(1)) dut_a (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata_a), .cpu_done(cpu_done_a), .cpu_stall(cpu_stall_a),
        .uart_req(uart_req), .uart_addr(uart_addr), .uart_wdata(uart_wdata), .uart_ack(uart_ack_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_we(mem_we_a), .mem_rdata(mem_rdata),
        .led_cs(led_cs_a), .led_wdata(led_wdata_a), .sw_cs(sw_cs_a), .sw_rdata(sw_rdata),
        .grant_uart(grant_uart_a)
    );

    mem_io_bus_arbiter #(.MEM_RD_LAT(3)) dut_b (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata_b), .cpu_done(cpu_done_b), .cpu_stall(cpu_stall_b),
        .uart_req(uart_req), .uart_addr(uart_addr), .uart_wdata(uart_wdata), .uart_ack(uart_ack_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_we(mem_we_b), .mem_rdata(mem_rdata),
        .led_cs(led_cs_b), .led_wdata(led_wdata_b), .sw_cs(sw_cs_b), .sw_rdata(sw_rdata),
        .grant_uart(grant_uart_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; cpu_req = 0; cpu_we = 0; uart_req = 0;
        cpu_addr = 0; cpu_wdata = 0; uart_addr = 0; uart_wdata = 0;
        mem_rdata = 0; sw_rdata = 0;
        cyc(); cyc(); cyc();
        chk("rst_cpu_done", 32'(cpu_done_a), 0);
        chk("rst_mem_we", 32'(mem_we_a), 0);
        chk("rst_grant_uart", 32'(grant_uart_a), 0);
        chk("rst_cpu_rdata", cpu_rdata_a, 0);
        chk("rst_mem_addr", mem_addr_a, 0);
        reset = 1'b0;
        cyc();

        // CPU store to memory
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        #1;
        chk("st_stall_idle", 32'(cpu_stall_a), 1);
        chk("st_we_idle", 32'(mem_we_a), 0);
        cyc();
        chk("st_mem_we", 32'(mem_we_a), 1);
        chk("st_mem_addr", mem_addr_a, 32'h10);
        chk("st_mem_wdata", mem_wdata_a, 32'hDEADBEEF);
        chk("st_cpu_done", 32'(cpu_done_a), 1);
        chk("st_stall_done", 32'(cpu_stall_a), 0);
        cpu_req = 0;
        cyc();
        chk("st_we_after", 32'(mem_we_a), 0);
        chk("st_done_after", 32'(cpu_done_a), 0);
        chk("st_addr_hold", mem_addr_a, 32'h10);

        // CPU load from memory, latency 1
        mem_rdata = 32'hDEADBEEF;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (cpu_done_a) begin lat = k; break; end
        end
        chk("ld1_latency", 32'(lat), 2);
        chk("ld1_rdata", cpu_rdata_a, 32'hDEADBEEF);
        chk("ld1_no_we", 32'(mem_we_a), 0);
        cpu_req = 0;
        reset = 1; cyc(); reset = 0; cyc();

        // CPU load from memory, latency 3
        mem_rdata = 32'hCAFEF00D;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (cpu_done_b) begin lat = k; break; end
        end
        chk("ld3_latency", 32'(lat), 4);
        chk("ld3_rdata", cpu_rdata_b, 32'hCAFEF00D);
        cpu_req = 0;
        reset = 1; cyc(); reset = 0; cyc();
        chk("rst_rdata_clr", cpu_rdata_a, 0);

        // LED store
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'hFFFF_FC60; cpu_wdata = 32'h0001_A5A5;
        cyc();
        chk("led_cs", 32'(led_cs_a), 1);
        chk("led_wdata", 32'(led_wdata_a), 32'hA5A5);
        chk("led_done", 32'(cpu_done_a), 1);
        chk("led_no_we", 32'(mem_we_a), 0);
        cpu_req = 0;
        cyc();
        chk("led_cs_off", 32'(led_cs_a), 0);
        chk("led_wdata_off", 32'(led_wdata_a), 0);

        // Switch load
        sw_rdata = 16'h1234;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'hFFFF_FC70;
        cyc();
        chk("sw_cs", 32'(sw_cs_a), 1);
        chk("sw_done_early", 32'(cpu_done_a), 0);
        cyc();
        chk("sw_cs_off", 32'(sw_cs_a), 0);
        chk("sw_done", 32'(cpu_done_a), 1);
        chk("sw_rdata", cpu_rdata_a, 32'h0000_1234);
        cpu_req = 0;
        cyc();
        chk("sw_rdata_hold", cpu_rdata_a, 32'h0000_1234);

        // Unmapped IO load
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'hFFFF_FC00;
        cyc();
        chk("unm_sw_cs", 32'(sw_cs_a), 0);
        chk("unm_led_cs", 32'(led_cs_a), 0);
        cyc();
        chk("unm_done", 32'(cpu_done_a), 1);
        chk("unm_rdata", cpu_rdata_a, 0);
        cpu_req = 0;
        cyc();

        // UART write into IO space is dropped
        uart_req = 1; uart_addr = 32'hFFFF_FC60; uart_wdata = 32'h5555;
        cyc();
        chk("uio_ack", 32'(uart_ack_a), 1);
        chk("uio_grant", 32'(grant_uart_a), 1);
        chk("uio_led_cs", 32'(led_cs_a), 0);
        chk("uio_mem_we", 32'(mem_we_a), 0);
        chk("uio_cpu_done", 32'(cpu_done_a), 0);
        uart_req = 0;
        cyc();

        // Simultaneous held requests alternate CPU, UART, CPU, UART
        reset = 1; cyc(); reset = 0; cyc();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h111;
        uart_req = 1; uart_addr = 32'h30; uart_wdata = 32'h222;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("rr%0d_grant_uart", i), 32'(grant_uart_a), 32'(i % 2));
            chk($sformatf("rr%0d_cpu_done", i), 32'(cpu_done_a), 32'((i + 1) % 2));
            chk($sformatf("rr%0d_uart_ack", i), 32'(uart_ack_a), 32'(i % 2));
            chk($sformatf("rr%0d_mem_we", i), 32'(mem_we_a), 1);
            chk($sformatf("rr%0d_mem_addr", i), mem_addr_a, (i % 2) ? 32'h30 : 32'h20);
            chk($sformatf("rr%0d_mem_wdata", i), mem_wdata_a, (i % 2) ? 32'h222 : 32'h111);
            cyc();
            chk($sformatf("rr%0d_gap_grant", i), 32'(grant_uart_a), 0);
            chk($sformatf("rr%0d_gap_we", i), 32'(mem_we_a), 0);
        end
        cpu_req = 0; uart_req = 0;
        cyc();

        // Reset while the latency-3 instance sits in RD_WAIT
        reset = 1; cyc(); reset = 0; cyc();
        mem_rdata = 32'h0BAD_0BAD;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        cyc();
        cyc();
        chk("rw_in_wait", 32'(dut_b.state), 32'(RD_WAIT));
        reset = 1; cpu_req = 0;
        cyc();
        chk("rw_state", 32'(dut_b.state), 32'(IDLE));
        chk("rw_done", 32'(cpu_done_b), 0);
        chk("rw_rdata", cpu_rdata_b, 0);
        chk("rw_mem_addr", mem_addr_b, 0);
        chk("rw_mem_wdata", mem_wdata_b, 0);
        chk("rw_stall", 32'(cpu_stall_b), 0);
        reset = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk($sformatf("rw_quiet%0d", k), 32'(cpu_done_b), 0);
        end
        mem_rdata = 32'h0000_0077;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (cpu_done_b) begin lat = k; break; end
        end
        chk("rw_next_latency", 32'(lat), 4);
        chk("rw_next_rdata", cpu_rdata_b, 32'h77);
        cpu_req = 0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_io_bus_arbiter.md
Name: mem_io_bus_arbiter

Overview:
Sequences and arbitrates every data-side access behind the CPU's memory/IO mux. There are two requesters: the CPU load/store path and the UART program loader, which is write-only.
- Decodes each address into data memory, LED or switch, and drives the memory and IO chip selects.
- Inserts read-latency wait states and returns a one-cycle completion pulse to the granted requester.

Parameters:
DATA_W, 32, data and address width (ISA width)
IO_BASE, 32'hFFFF_FC00, addresses >= IO_BASE are IO space
LED_ADDR, 32'hFFFF_FC60, LED write register
SW_ADDR, 32'hFFFF_FC70, switch read register
MEM_RD_LAT, 1, data-memory read latency in cycles (1..3)

Ports:
clock  in  1  system clock, single domain
reset  in  1  synchronous, active-high
cpu_req  in  1  CPU access request, held until cpu_done
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  DATA_W  byte address from ALU result
cpu_wdata  in  DATA_W  store data from register file
cpu_rdata  out  DATA_W  load data, valid during cpu_done, held afterwards
cpu_done  out  1  one-cycle completion pulse
cpu_stall  out  1  cpu_req & ~cpu_done (combinational)
uart_req  in  1  loader write request, held until uart_ack
uart_addr  in  DATA_W  loader word address
uart_wdata  in  DATA_W  loader data
uart_ack  out  1  one-cycle completion pulse
mem_addr  out  DATA_W  data-memory address
mem_wdata  out  DATA_W  data-memory write data
mem_we  out  1  data-memory write enable
mem_rdata  in  DATA_W  data-memory read data
led_cs  out  1  LED chip select, one-cycle pulse
led_wdata  out  16  LED data, cpu_wdata[15:0] while led_cs = 1, else 0
sw_cs  out  1  switch chip select, one-cycle pulse
sw_rdata  in  16  switch value
grant_uart  out  1  1 while the current access belongs to the UART

Behaviour:
- Reset (sync, high):
  - Every output goes to 0 and the state goes to IDLE.
  - The round-robin pointer last_grant is set to UART, so the CPU wins the first tie.
  - An access in flight is dropped with no done or ack pulse; memory is never written after reset is sampled.
- States: IDLE, MEM_WR, MEM_RD, RD_WAIT, IO_WR, IO_RD, RESP.
- IDLE samples the requests:
  - One request: grant it.
  - Both requests: grant the one other than last_grant, then update last_grant.
  - The winner's address, write data and we are latched into internal registers.
- Decode of the latched address:
  - addr < IO_BASE: memory.
  - addr == LED_ADDR: LED.
  - addr == SW_ADDR: switch.
  - Any other IO address: unmapped.
- CPU store to memory: IDLE -> MEM_WR. mem_we = 1 for exactly one cycle, cpu_done in the same cycle, then IDLE. Latency is 1 cycle after the request is sampled.
- CPU load from memory:
  - IDLE -> MEM_RD, driving mem_addr.
  - RD_WAIT counts MEM_RD_LAT-1 extra cycles.
  - RESP captures mem_rdata into cpu_rdata and pulses cpu_done.
  - Total latency is MEM_RD_LAT+1 cycles.
- CPU store to LED: IO_WR pulses led_cs with led_wdata, and cpu_done in the same cycle.
- CPU load from switch: IO_RD pulses sw_cs and registers {16'h0, sw_rdata}. RESP pulses cpu_done. Latency is 2 cycles.
- Unmapped IO, a load from LED_ADDR, or a store to SW_ADDR: no chip select fires. A load returns 0. Completion timing matches IO_WR for stores and IO_RD for loads.
- UART write:
  - Memory target: as MEM_WR, but with uart_ack and grant_uart = 1.
  - IO-region target: ignored, no chip select and no mem_we; uart_ack is pulsed after 1 cycle.
- After a completion pulse the state always returns to IDLE. Back-to-back requests are re-arbitrated, so there is at least one IDLE cycle between accesses.
- mem_addr and mem_wdata hold their last value between accesses. mem_we, led_cs and sw_cs are 0 outside their access states.
- Requester signals must be stable while req is high. A change mid-access is not sampled, because the values are latched in IDLE.
- cpu_rdata updates only on a CPU load completion.

Decomposition:
- Shared package: IO_BASE, LED_ADDR and SW_ADDR constants, the state encoding, and a region enum (MEM, LED, SW, UNMAPPED).
- One sub-module, mem_io_addr_decode: combinational, address in -> region enum out.

Test Plan:
- Reset, then CPU store addr 0x10, data 0xDEADBEEF -> mem_we = 1 for one cycle with mem_addr 0x10, cpu_done in the same cycle, cpu_stall high for exactly 1 cycle.
- CPU load 0x10 with MEM_RD_LAT = 1 and mem_rdata = 0xDEADBEEF -> cpu_done 2 cycles after the request is sampled, cpu_rdata = 0xDEADBEEF. Repeat with MEM_RD_LAT = 3 -> 4 cycles.
- CPU store 0xFFFF_FC60, data 0x0001_A5A5 -> led_cs pulse with led_wdata 0xA5A5, no mem_we. Load 0xFFFF_FC70 with sw_rdata 0x1234 -> sw_cs pulse, cpu_rdata 0x0000_1234.
- cpu_req and uart_req asserted together and held for 4 accesses -> grants alternate CPU, UART, CPU, UART. grant_uart is high only during the UART accesses.
- CPU load 0xFFFF_FC00 (unmapped) -> no chip select, cpu_rdata 0. UART write to 0xFFFF_FC60 -> uart_ack, no led_cs, no mem_we.
- Reset asserted during RD_WAIT -> no cpu_done, all outputs 0 the next cycle, state IDLE. The next CPU request completes normally.
